// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - Shared Ascon-128a constants, state type and FSM encoding
package ascon_pkg;

  typedef logic [63:0] word_t;

  // x0 occupies the most significant word, so {x0,x1} is the 128-bit rate.
  typedef struct packed {
    word_t x0;
    word_t x1;
    word_t x2;
    word_t x3;
    word_t x4;
  } state_t;

  localparam word_t       IV_128A   = 64'h80800c0800000000;
  localparam int unsigned RATE_BITS = 128;
  localparam logic [7:0]  PAD_BYTE  = 8'h80;
  localparam word_t       PAD_WORD  = {PAD_BYTE, 56'd0};

  localparam logic [7:0] RC_TABLE [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD1,
    ST_AD2,
    ST_CT,
    ST_FIN
  } fsm_t;

  function automatic logic [7:0] round_const(input logic [3:0] idx);
    round_const = (idx < 4'd12) ? RC_TABLE[idx] : 8'h00;
  endfunction

  function automatic word_t ror64(input word_t x, input int unsigned n);
    ror64 = (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - One combinational Ascon permutation round (pc, ps, pl)
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] rnd_i,
  output state_t     state_o
);

  word_t a0, a1, a2, a3, a4;
  word_t b0, b1, b2, b3, b4;
  word_t s0, s1, s2, s3, s4;

  // Constant addition folded into the S-box input mixing of x2.
  assign a0 = state_i.x0 ^ state_i.x4;
  assign a1 = state_i.x1;
  assign a2 = state_i.x2 ^ {56'd0, round_const(rnd_i)} ^ state_i.x1;
  assign a3 = state_i.x3;
  assign a4 = state_i.x4 ^ state_i.x3;

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  assign state_o.x0 = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign state_o.x1 = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign state_o.x2 = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign state_o.x3 = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign state_o.x4 = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);

endmodule

// File: rtl/ascon128a_decrypt.sv
// rtl/ascon128a_decrypt.sv - Round-iterative Ascon-128a decryption of one AD block and one CT block
// Optional ASCON_DEC_PT_GATE_EN: P is forced to zero whenever the tag does not verify.
module ascon128a_decrypt
  import ascon_pkg::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [127:0]         SK,
  input  logic [127:0]         N,
  input  logic [127:0]         A,
  input  logic [127:0]         C,
  input  logic [127:0]         T,
  output logic                 busy,
  output logic                 done,
  output logic [127:0]         P,
  output logic                 valid
);

  localparam logic [3:0] LAST_A   = 4'(ROUNDS_A - 1);
  localparam logic [3:0] LAST_B   = 4'(ROUNDS_B - 1);
  localparam logic [3:0] RC_OFF_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RC_OFF_B = 4'(12 - ROUNDS_B);

  fsm_t                   fsm_q, fsm_d;
  logic [3:0]             cnt_q, cnt_d;
  state_t                 s_q, s_d, s_rnd;
  logic [127:0]           key_q, key_d;
  logic [RATE_BITS-1:0]   ad_q, ad_d;
  logic [RATE_BITS-1:0]   ct_q, ct_d;
  logic [127:0]           tag_q, tag_d;
  logic [RATE_BITS-1:0]   ptmp_q, ptmp_d;
  logic [RATE_BITS-1:0]   p_q, p_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  logic                   long_phase;
  logic                   is_last;
  logic [3:0]             rnd_idx;
  logic [127:0]           tag_calc;
  logic                   tag_ok;

  ascon_round u_round (
    .state_i (s_q),
    .rnd_i   (rnd_idx),
    .state_o (s_rnd)
  );

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    key_d   = key_q;
    ad_d    = ad_q;
    ct_d    = ct_q;
    tag_d   = tag_q;
    ptmp_d  = ptmp_q;
    p_d     = p_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    long_phase = (fsm_q == ST_INIT) || (fsm_q == ST_FIN);
    is_last    = (cnt_q == (long_phase ? LAST_A : LAST_B));
    rnd_idx    = (long_phase ? RC_OFF_A : RC_OFF_B) + cnt_q;
    tag_calc   = {s_rnd.x3, s_rnd.x4} ^ key_q;
    tag_ok     = (tag_calc == tag_q);

    if (fsm_q == ST_IDLE) begin
      if (start) begin
        s_d   = {IV_128A, SK, N};
        key_d = SK;
        ad_d  = A;
        ct_d  = C;
        tag_d = T;
        cnt_d = 4'd0;
        fsm_d = ST_INIT;
      end
    end else begin
      s_d   = s_rnd;
      cnt_d = is_last ? 4'd0 : cnt_q + 4'd1;
      if (is_last) begin
        case (fsm_q)
          ST_INIT: begin
            s_d.x3 = s_rnd.x3 ^ key_q[127:64];
            s_d.x4 = s_rnd.x4 ^ key_q[63:0];
            s_d.x0 = s_rnd.x0 ^ ad_q[127:64];
            s_d.x1 = s_rnd.x1 ^ ad_q[63:0];
            fsm_d  = ST_AD1;
          end
          ST_AD1: begin
            // A is a full block, so a separate padding-only block follows it.
            s_d.x0 = s_rnd.x0 ^ PAD_WORD;
            fsm_d  = ST_AD2;
          end
          ST_AD2: begin
            s_d.x4 = s_rnd.x4 ^ 64'd1;
            ptmp_d = {s_rnd.x0, s_rnd.x1} ^ ct_q;
            s_d.x0 = ct_q[127:64];
            s_d.x1 = ct_q[63:0];
            fsm_d  = ST_CT;
          end
          ST_CT: begin
            s_d.x0 = s_rnd.x0 ^ PAD_WORD;
            s_d.x2 = s_rnd.x2 ^ key_q[127:64];
            s_d.x3 = s_rnd.x3 ^ key_q[63:0];
            fsm_d  = ST_FIN;
          end
          ST_FIN: begin
            valid_d = tag_ok;
`ifdef ASCON_DEC_PT_GATE_EN
            p_d     = tag_ok ? ptmp_q : '0;
`else
            p_d     = ptmp_q;
`endif
            done_d  = 1'b1;
            fsm_d   = ST_IDLE;
          end
          default: fsm_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= 4'd0;
      s_q     <= '0;
      key_q   <= '0;
      ad_q    <= '0;
      ct_q    <= '0;
      tag_q   <= '0;
      ptmp_q  <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      key_q   <= key_d;
      ad_q    <= ad_d;
      ct_q    <= ct_d;
      tag_q   <= tag_d;
      ptmp_q  <= ptmp_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (fsm_q != ST_IDLE);
  assign done  = done_q;
  assign P     = p_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_ascon128a_decrypt.sv
// tb/tb_ascon128a_decrypt.sv - Scoreboard bench for ascon128a_decrypt with an independent Ascon-128a encryption model
module tb_ascon128a_decrypt;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [127:0] SK = '0, N = '0, A = '0, C = '0, T = '0;
  logic         busy, done, valid;
  logic [127:0] P;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [127:0] p;
    logic         valid;
    int           cyc;
    int           id;
  } exp_t;
  exp_t exp_q[$];
  int   next_id = 0;

  // Ascon 5-bit S-box, x0 as the most significant input/output bit.
  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  ascon128a_decrypt #(
    .ROUNDS_A (12),
    .ROUNDS_B (8)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .SK    (SK),
    .N     (N),
    .A     (A),
    .C     (C),
    .T     (T),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .valid (valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
    logic [127:0] d;
    d = {w, w} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s_in, input int nr);
    logic [63:0]  w [5];
    logic [63:0]  o [5];
    logic [4:0]   col, sb;
    logic [319:0] s;
    s = s_in;
    for (int i = 0; i < 5; i++) w[i] = s[319 - 64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      w[2] = w[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
        sb  = sbox_tab[col];
        for (int j = 0; j < 5; j++) o[j][b] = sb[4 - j];
      end
      w[0] = o[0] ^ rotr(o[0], 19) ^ rotr(o[0], 28);
      w[1] = o[1] ^ rotr(o[1], 61) ^ rotr(o[1], 39);
      w[2] = o[2] ^ rotr(o[2], 1)  ^ rotr(o[2], 6);
      w[3] = o[3] ^ rotr(o[3], 10) ^ rotr(o[3], 17);
      w[4] = o[4] ^ rotr(o[4], 7)  ^ rotr(o[4], 41);
    end
    for (int i = 0; i < 5; i++) s[319 - 64*i -: 64] = w[i];
    return s;
  endfunction

  function automatic void enc(input logic [127:0] k, n, a, p,
                              output logic [127:0] c, t);
    logic [319:0] s;
    s = {64'h80800c0800000000, k, n};
    s = perm(s, 12);
    s[127:0]   = s[127:0] ^ k;
    s[319:192] = s[319:192] ^ a;
    s = perm(s, 8);
    s[319:312] = s[319:312] ^ 8'h80;
    s = perm(s, 8);
    s[0]       = s[0] ^ 1'b1;
    s[319:192] = s[319:192] ^ p;
    c = s[319:192];
    s = perm(s, 8);
    s[319:312] = s[319:312] ^ 8'h80;
    s[191:64]  = s[191:64] ^ k;
    s = perm(s, 12);
    t = s[127:0] ^ k;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_inputs(input logic [127:0] k, n, a, p, tmask);
    logic [127:0] c, t;
    enc(k, n, a, p, c, t);
    SK = k; N = n; A = a; C = c; T = t ^ tmask;
  endtask

  task automatic push_exp(input logic [127:0] p, tmask, input int done_cyc);
    exp_t e;
    e.valid = (tmask == '0);
`ifdef ASCON_DEC_PT_GATE_EN
    e.p = e.valid ? p : '0;
`else
    e.p = p;
`endif
    e.cyc = done_cyc;
    e.id  = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [127:0] k, n, a, p, tmask, input bit push);
    set_inputs(k, n, a, p, tmask);
    start = 1'b1;
    if (push) push_exp(p, tmask, cyc + 1 + 48);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      tick();
      b++;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    tick();
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding request.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (!RST && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("req%0d_p", e.id), P, e.p);
        chk($sformatf("req%0d_valid", e.id), 128'(valid), 128'(e.valid));
        chk($sformatf("req%0d_done_cycle", e.id), 128'(cyc), 128'(e.cyc));
        chk($sformatf("req%0d_busy_at_done", e.id), 128'(busy), 128'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N1 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A1 = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] P1 = 128'h303132333435363738393a3b3c3d3e3f;
  localparam logic [127:0] K2 = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] N2 = 128'h00000000000000000000000000000000;
  localparam logic [127:0] A2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P2 = 128'hdeadbeefcafebabe0badf00d12345678;
  localparam logic [127:0] K3 = 128'h80000000000000000000000000000001;
  localparam logic [127:0] N3 = 128'h5a5a5a5aa5a5a5a55a5a5a5aa5a5a5a5;
  localparam logic [127:0] A3 = 128'h00000000000000000000000000000000;
  localparam logic [127:0] P3 = 128'hffffffff00000000ffffffff00000001;

  initial begin
    repeat (3) tick();
    chk("reset_busy",  128'(busy),  128'd0);
    chk("reset_done",  128'(done),  128'd0);
    chk("reset_valid", 128'(valid), 128'd0);
    chk("reset_p",     P,           128'd0);

    // Reset and start on the same edge: reset wins.
    set_inputs(K1, N1, A1, P1, '0);
    start = 1'b1;
    tick();
    chk("rst_vs_start_busy", 128'(busy), 128'd0);
    RST   = 1'b0;
    start = 1'b0;
    tick();
    chk("after_rst_start_busy", 128'(busy), 128'd0);

    issue('0, '0, '0, '0, '0, 1'b1);                 drain();
    issue('0, '0, '0, '0, 128'd1, 1'b1);             drain();
    issue(K1, N1, A1, P1, '0, 1'b1);                 drain();
    issue(K2, N2, A2, P2, '0, 1'b1);                 drain();
    issue(K2, N2, A2, P2, {1'b1, 127'd0}, 1'b1);     drain();
    issue(K3, N3, A3, P3, '0, 1'b1);                 drain();

    // Reset asserted on edge k+20 of a running request.
    issue(K1, N1, A1, P1, '0, 1'b0);
    repeat (19) tick();
    RST = 1'b1;
    tick();
    chk("midrst_busy",  128'(busy),  128'd0);
    chk("midrst_done",  128'(done),  128'd0);
    chk("midrst_valid", 128'(valid), 128'd0);
    chk("midrst_p",     P,           128'd0);
    RST = 1'b0;
    tick();
    issue(K3, N3, A3, P3, '0, 1'b1);                 drain();

    // A second start while busy is ignored.
    issue(K1, N1, A1, P1, '0, 1'b1);
    repeat (4) tick();
    set_inputs(K2, N2, A2, P2, '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // start held high: the second request is accepted in the done cycle.
    set_inputs(K2, N2, A2, P2, '0);
    start = 1'b1;
    push_exp(P2, '0, cyc + 1 + 48);
    tick();
    set_inputs(K1, N1, A1, P1, '0);
    push_exp(P1, '0, cyc + 1 + 48 + 48);
    repeat (49) tick();
    start = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
